demux16_sipo: RTL and testbench

- 1:16 demultiplexing deserializer. Each valid serial bit on din is steered into word-bit position sel, and sel advances automatically.
- After 16 accepted bits, the assembled word moves to an output holding register. It is then offered downstream on a valid/ready handshake.
- Sits at the receive end of a serial lane and feeds parallel logic.

---
 rtl/demux16_sipo_if.sv | 27 ++
 rtl/demux16_sipo.sv | 148 ++++++++++++++
 tb/tb_demux16_sipo.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/demux16_sipo_if.sv
// Serial-in / parallel-out bus for demux16_sipo: serial input, control, word handshake and status.
// The master side drives the serial lane and consumes words; the slave side is the deserializer.
interface demux16_sipo_if #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
);
    logic             din;
    logic             din_valid;
    logic             clr;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             overrun;
    logic             parity_err;

    modport master (
        output din, din_valid, clr, dout_ready,
        input  dout, dout_valid, sel, busy, overrun, parity_err
    );

    modport slave (
        input  din, din_valid, clr, dout_ready,
        output dout, dout_valid, sel, busy, overrun, parity_err
    );
endinterface

// File: rtl/demux16_sipo.sv
// 1:16 demultiplexing deserializer: each valid serial bit lands at position sel, full words go to a
// valid/ready holding register. Define DEMUX16_PARITY_EN to append an even-parity bit to each word.
module demux16_sipo #(
    parameter int WIDTH     = 16,
    parameter int SEL_W     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    demux16_sipo_if.slave bus
);

    localparam logic [SEL_W-1:0] SEL_START = LSB_FIRST ? '0 : SEL_W'(WIDTH - 1);
    localparam logic [SEL_W-1:0] SEL_LAST  = LSB_FIRST ? SEL_W'(WIDTH - 1) : '0;

`ifdef DEMUX16_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PARITY} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_COLLECT} state_t;
`endif

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] collect_q, collect_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
`ifdef DEMUX16_PARITY_EN
    logic             parity_err_q, parity_err_d;
`endif

    logic             word_done;
    logic [WIDTH-1:0] word;

    always_comb begin
        // NOTE: every next-state value gets a default up front so no path leaves it unassigned (no latches).
        state_d      = state_q;
        sel_d        = sel_q;
        collect_d    = collect_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        busy_d       = busy_q;
        overrun_d    = overrun_q;
`ifdef DEMUX16_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        word_done    = 1'b0;
        word         = collect_q;

        if (bus.clr) begin
            // Abort outranks any same-cycle bit or transfer; the held word itself is kept.
            state_d      = S_IDLE;
            sel_d        = SEL_START;
            collect_d    = '0;
            busy_d       = 1'b0;
            dout_valid_d = 1'b0;
            overrun_d    = 1'b0;
`ifdef DEMUX16_PARITY_EN
            parity_err_d = 1'b0;
`endif
        end else begin
            if (dout_valid_q && bus.dout_ready) dout_valid_d = 1'b0;

            if (bus.din_valid) begin
                case (state_q)
                    S_IDLE, S_COLLECT: begin
                        collect_d[sel_q] = bus.din;
                        busy_d           = 1'b1;
                        if (sel_q == SEL_LAST) begin
                            sel_d = SEL_START;
`ifdef DEMUX16_PARITY_EN
                            state_d = S_PARITY;
`else
                            word      = collect_d;
                            word_done = 1'b1;
                            state_d   = S_IDLE;
`endif
                        end else begin
                            sel_d   = LSB_FIRST ? sel_q + SEL_W'(1) : sel_q - SEL_W'(1);
                            state_d = S_COLLECT;
                        end
                    end
`ifdef DEMUX16_PARITY_EN
                    S_PARITY: begin
                        word      = collect_q;
                        word_done = 1'b1;
                        state_d   = S_IDLE;
                        if (^{collect_q, bus.din}) parity_err_d = 1'b1;
                    end
`endif
                    default: state_d = S_IDLE;
                endcase
            end

            // A finished word overwrites the holding register only if it is empty or drained this cycle.
            if (word_done) begin
                collect_d = '0;
                busy_d    = 1'b0;
                if (!dout_valid_q || bus.dout_ready) begin
                    dout_d       = word;
                    dout_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the combinational block above uses blocking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sel_q        <= SEL_START;
            collect_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef DEMUX16_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            collect_q    <= collect_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
`ifdef DEMUX16_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.sel        = sel_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;
`ifdef DEMUX16_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_demux16_sipo.sv
// Directed bench for demux16_sipo (LSB_FIRST=1): a per-cycle vector table for a plain word, then
// hand-written sequences for gaps, overrun, simultaneous drain, clear, async reset and parity.
module tb_demux16_sipo;

    localparam int WIDTH = 16;
    localparam int SEL_W = 4;
`ifdef DEMUX16_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    localparam logic [15:0] W1 = 16'h3f0a;
    localparam logic [15:0] W2 = 16'h00ff;
    localparam logic [15:0] W3 = 16'hc001;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux16_sipo_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

    demux16_sipo #(.WIDTH(WIDTH), .SEL_W(SEL_W), .LSB_FIRST(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        din_valid;
        logic        din;
        logic        clr;
        logic        dout_ready;
        logic [15:0] e_dout;
        logic        e_dv;
        logic [3:0]  e_sel;
        logic        e_busy;
        logic        e_ovr;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] e_dout, input logic e_dv,
                             input logic [3:0] e_sel, input logic e_busy, input logic e_ovr);
        check({tag, ".dout"},       32'(bus.dout),       32'(e_dout));
        check({tag, ".dout_valid"}, 32'(bus.dout_valid), 32'(e_dv));
        check({tag, ".sel"},        32'(bus.sel),        32'(e_sel));
        check({tag, ".busy"},       32'(bus.busy),       32'(e_busy));
        check({tag, ".overrun"},    32'(bus.overrun),    32'(e_ovr));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one full word LSB first (plus even parity when enabled); optionally raises
    // dout_ready only on the final beat so the transfer and the drain coincide.
    task automatic send_word(input logic [15:0] w, input bit last_ready);
        int n;
        n = WIDTH + PAR_BITS;
        for (int i = 0; i < n; i++) begin
            bus.din_valid = 1'b1;
            bus.din       = (i < WIDTH) ? w[i % WIDTH] : ^w;
            if (last_ready && i == n - 1) bus.dout_ready = 1'b1;
            step();
        end
        bus.din_valid = 1'b0;
        if (last_ready) bus.dout_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;

        // Plain word W1, ready held high: transfer one clock after the last data bit, drain next cycle.
        for (int i = 0; i < WIDTH; i++) begin
            v.din_valid = 1'b1; v.din = W1[i]; v.clr = 1'b0; v.dout_ready = 1'b1;
            v.e_sel = 4'((i + 1) % WIDTH); v.e_ovr = 1'b0;
            if (i == WIDTH - 1 && PAR_BITS == 0) begin
                v.e_dout = W1; v.e_dv = 1'b1; v.e_busy = 1'b0;
            end else begin
                v.e_dout = '0; v.e_dv = 1'b0; v.e_busy = 1'b1;
            end
            vecs.push_back(v);
        end
        if (PAR_BITS != 0) begin
            v.din_valid = 1'b1; v.din = ^W1; v.clr = 1'b0; v.dout_ready = 1'b1;
            v.e_dout = W1; v.e_dv = 1'b1; v.e_sel = 4'd0; v.e_busy = 1'b0; v.e_ovr = 1'b0;
            vecs.push_back(v);
        end
        v.din_valid = 1'b0; v.din = 1'b0; v.clr = 1'b0; v.dout_ready = 1'b1;
        v.e_dout = W1; v.e_dv = 1'b0; v.e_sel = 4'd0; v.e_busy = 1'b0; v.e_ovr = 1'b0;
        vecs.push_back(v);

        bus.din = 1'b0; bus.din_valid = 1'b0; bus.clr = 1'b0; bus.dout_ready = 1'b0;
        #12;
        check_out("reset", 16'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        check("reset.parity_err", 32'(bus.parity_err), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) begin
            bus.din_valid  = vecs[i].din_valid;
            bus.din        = vecs[i].din;
            bus.clr        = vecs[i].clr;
            bus.dout_ready = vecs[i].dout_ready;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_dv, vecs[i].e_sel,
                      vecs[i].e_busy, vecs[i].e_ovr);
        end
        bus.din_valid = 1'b0;

        // Valid every other cycle: sel and busy hold through each gap.
        bus.dout_ready = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            bus.din_valid = 1'b1; bus.din = W1[i];
            step();
            bus.din_valid = 1'b0;
            if (i < WIDTH - 1) begin
                check($sformatf("gap.sel_bit%0d", i), 32'(bus.sel), 32'(i + 1));
                check($sformatf("gap.busy_bit%0d", i), 32'(bus.busy), 32'd1);
                step();
                check($sformatf("gap.sel_idle%0d", i), 32'(bus.sel), 32'(i + 1));
            end
        end
        if (PAR_BITS != 0) begin
            check("gap.busy_parity", 32'(bus.busy), 32'd1);
            bus.din_valid = 1'b1; bus.din = ^W1;
            step();
            bus.din_valid = 1'b0;
        end
        check_out("gap.done", W1, 1'b1, 4'd0, 1'b0, 1'b0);
        step();
        check("gap.drained", 32'(bus.dout_valid), 32'd0);

        // Overrun: second word dropped while the first is held, then drain and clear.
        bus.dout_ready = 1'b0;
        send_word(W1, 1'b0);
        check_out("ovr.first", W1, 1'b1, 4'd0, 1'b0, 1'b0);
        send_word(W2, 1'b0);
        check_out("ovr.second", W1, 1'b1, 4'd0, 1'b0, 1'b1);
        bus.dout_ready = 1'b1;
        step();
        bus.dout_ready = 1'b0;
        check_out("ovr.drain", W1, 1'b0, 4'd0, 1'b0, 1'b1);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        check_out("ovr.clr", W1, 1'b0, 4'd0, 1'b0, 1'b0);

        // Transfer on the same edge the held word drains: no gap in dout_valid, no overrun.
        send_word(W1, 1'b0);
        check_out("sim.first", W1, 1'b1, 4'd0, 1'b0, 1'b0);
        send_word(W2, 1'b1);
        check_out("sim.second", W2, 1'b1, 4'd0, 1'b0, 1'b0);
        bus.dout_ready = 1'b1;
        step();
        bus.dout_ready = 1'b0;
        check("sim.drain", 32'(bus.dout_valid), 32'd0);

        // Clear after 6 bits, colliding with a valid bit: clear wins and the next word aligns at bit 0.
        for (int i = 0; i < 6; i++) begin
            bus.din_valid = 1'b1; bus.din = 1'b1;
            step();
        end
        bus.din_valid = 1'b0;
        check_out("clr.partial", W2, 1'b0, 4'd6, 1'b1, 1'b0);
        bus.clr = 1'b1; bus.din_valid = 1'b1; bus.din = 1'b1;
        step();
        bus.clr = 1'b0; bus.din_valid = 1'b0;
        check_out("clr.abort", W2, 1'b0, 4'd0, 1'b0, 1'b0);
        send_word(W3, 1'b0);
        check_out("clr.next", W3, 1'b1, 4'd0, 1'b0, 1'b0);

        // Async reset between edges with a held word, overrun and a partial word all present.
        send_word(W2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.din_valid = 1'b1; bus.din = 1'b1;
            step();
        end
        bus.din_valid = 1'b0;
        check_out("rst.before", W3, 1'b1, 4'd5, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_out("rst.async", 16'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        #10 rst_n = 1'b1;
        step();
        send_word(W1, 1'b0);
        check_out("rst.after", W1, 1'b1, 4'd0, 1'b0, 1'b0);

`ifdef DEMUX16_PARITY_EN
        // Deliberately wrong parity bit, then the correct one after a clear.
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        bus.dout_ready = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            bus.din_valid = 1'b1; bus.din = W1[i];
            step();
        end
        check("par.busy", 32'(bus.busy), 32'd1);
        bus.din = 1'b1;
        step();
        bus.din_valid = 1'b0;
        check("par.bad_err", 32'(bus.parity_err), 32'd1);
        check("par.bad_dout", 32'(bus.dout), 32'(W1));
        check("par.bad_dv", 32'(bus.dout_valid), 32'd1);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        check("par.clr", 32'(bus.parity_err), 32'd0);
        for (int i = 0; i < WIDTH; i++) begin
            bus.din_valid = 1'b1; bus.din = W1[i];
            step();
        end
        bus.din = 1'b0;
        step();
        bus.din_valid = 1'b0;
        check("par.good_err", 32'(bus.parity_err), 32'd0);
        check("par.good_dout", 32'(bus.dout), 32'(W1));
        bus.dout_ready = 1'b0;
`else
        check("noparity.err", 32'(bus.parity_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
